// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks to instruction memory over
// a req/ack handshake and holds one fetched word in an output slot for F/D.
// Redirects from D flush the slot. A redirect that arrives while a request is
// outstanding parks its target until the memory acks, because the request
// cannot be withdrawn once raised.
// Optional feature: define FETCH_CNT_EN to enable the FETCH_CNT/BUBBLE_CNT
// delivery counters. Without it both ports are tied to zero.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STALL_D,
  input  logic        NPC_SEL,
  input  logic [31:0] NPC_D,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] PCadd4F,
  output logic [31:0] INSTR_F,
  output logic [31:0] PC,
  output logic        VALID_F,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] BUBBLE_CNT
);

  typedef enum logic {S_FETCH, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcs_q, pcs_d;
  logic        valid_q, valid_d;
  logic [31:0] redir_q, redir_d;
  logic        req_int;
  logic        free;
  logic [31:0] tgt;

  // Slot can accept a new word when it is empty or being consumed this edge.
  assign free = !valid_q || !STALL_D;
  // Redirect targets are word-aligned; the low two bits are dropped.
  assign tgt  = NPC_D & ~32'h3;

  // Next-state and memory-request logic for the FETCH/DRAIN machine.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcs_d   = pcs_q;
    valid_d = valid_q;
    redir_d = redir_q;
    req_int = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_int = free;
        if (NPC_SEL) begin
          valid_d = 1'b0;
          inst_d  = NOP_WORD;
          if (req_int && !im_ack) begin
            // Request in flight: remember the target, wait for the ack.
            redir_d = tgt;
            state_d = S_DRAIN;
          end else begin
            // Nothing outstanding (or acked now, data discarded).
            pc_d = tgt;
          end
        end else if (req_int && im_ack) begin
          inst_d  = im_rdata;
          pcs_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end else if (!STALL_D) begin
          valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        req_int = 1'b1;
        valid_d = 1'b0;
        if (NPC_SEL) redir_d = tgt;
        if (im_ack) begin
          // Stale word is dropped; newest redirect target wins.
          pc_d    = NPC_SEL ? tgt : redir_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // PC, slot and pending-redirect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_WORD;
      pcs_q   <= RESET_PC;
      valid_q <= 1'b0;
      redir_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcs_q   <= pcs_d;
      valid_q <= valid_d;
      redir_q <= redir_d;
    end
  end

  // A pending request is abandoned the moment reset rises.
  assign im_req  = req_int && !reset;
  assign im_addr = pc_q;
  assign INSTR_F = valid_q ? inst_q : NOP_WORD;
  assign PC      = pcs_q;
  assign PCadd4F = pcs_q + 32'd4;
  assign VALID_F = valid_q;

`ifdef FETCH_CNT_EN
  logic [31:0] fcnt_q, bcnt_q;

  // Count what F/D actually captures: real instructions versus bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= 32'h0;
      bcnt_q <= 32'h0;
    end else if (!STALL_D) begin
      if (valid_q) fcnt_q <= fcnt_q + 32'd1;
      else         bcnt_q <= bcnt_q + 32'd1;
    end
  end

  assign FETCH_CNT  = fcnt_q;
  assign BUBBLE_CNT = bcnt_q;
`else
  assign FETCH_CNT  = 32'h0;
  assign BUBBLE_CNT = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model and a
// scoreboard of expected deliveries (PC plus bubble gap before it).
module tb_fetch_unit;

`ifdef FETCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk, reset, STALL_D, NPC_SEL;
  logic [31:0] NPC_D;
  logic        im_req, im_ack;
  logic [31:0] im_addr, im_rdata;
  logic [31:0] PCadd4F, INSTR_F, PC, FETCH_CNT, BUBBLE_CNT;
  logic        VALID_F;

  fetch_unit dut (
    .clk(clk), .reset(reset), .STALL_D(STALL_D), .NPC_SEL(NPC_SEL), .NPC_D(NPC_D),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .PCadd4F(PCadd4F), .INSTR_F(INSTR_F), .PC(PC), .VALID_F(VALID_F),
    .FETCH_CNT(FETCH_CNT), .BUBBLE_CNT(BUBBLE_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [31:0] pc; int gap; } exp_t;
  exp_t q[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: acks once a request has been pending for lat cycles.
  int lat = 1000;
  int wcnt;
  always @(posedge clk or posedge reset) begin
    if (reset)                 wcnt <= 0;
    else if (im_req && !im_ack) wcnt <= wcnt + 1;
    else                        wcnt <= 0;
  end
  assign im_ack   = im_req && (wcnt >= lat);
  assign im_rdata = memfn(im_addr);

  // Delivery monitor: whatever F/D captures at the next edge.
  int          run, n_inst, n_bub;
  logic        prev_pend;
  logic [31:0] prev_addr;
  exp_t        e;
  always @(negedge clk) begin
    if (reset) begin
      run = 0; n_inst = 0; n_bub = 0; prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("req_held", {31'b0, im_req}, 32'd1);
        chk("addr_held", im_addr, prev_addr);
      end
      if (!STALL_D) begin
        if (VALID_F) begin
          if (q.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL unexpected: observed PC %h expected no delivery", PC);
          end else begin
            e = q.pop_front();
            chk("pc", PC, e.pc);
            chk("instr", INSTR_F, memfn(e.pc));
            chk("pcadd4", PCadd4F, e.pc + 32'd4);
            if (e.gap >= 0) chk("gap", 32'(run), 32'(e.gap));
          end
          n_inst++; run = 0;
        end else begin
          chk("bubble", INSTR_F, 32'h0);
          run++; n_bub++;
        end
      end
      prev_pend = im_req && !im_ack;
      prev_addr = im_addr;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] pc, input int gap);
    exp_t x;
    x.pc = pc; x.gap = gap;
    q.push_back(x);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $error("FAIL timeout: observed %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; STALL_D = 1'b0; NPC_SEL = 1'b0; NPC_D = 32'h0;
    tick(); tick();
    q.delete();
  endtask

  initial begin
    reset = 1'b1; STALL_D = 1'b0; NPC_SEL = 1'b0; NPC_D = 32'h0;
    // Reset state
    do_reset();
    chk("rst_req", {31'b0, im_req}, 32'd0);
    chk("rst_instr", INSTR_F, 32'h0);
    chk("rst_pc", PC, 32'h3000);
    chk("rst_pcadd4", PCadd4F, 32'h3004);
    chk("rst_valid", {31'b0, VALID_F}, 32'd0);
    chk("rst_fcnt", FETCH_CNT, 32'h0);
    chk("rst_bcnt", BUBBLE_CNT, 32'h0);

    // Same-cycle ack: back-to-back delivery
    lat = 0;
    push(32'h3000, 1); push(32'h3004, 0); push(32'h3008, 0);
    reset = 1'b0;
    wait_empty();
    STALL_D = 1'b1; lat = 1000;

    // Two-cycle ack latency: two bubbles between instructions
    do_reset();
    lat = 2;
    push(32'h3000, 3); push(32'h3004, 2); push(32'h3008, 2);
    reset = 1'b0;
    wait_empty();
    STALL_D = 1'b1; lat = 1000;

    // Stall with a full slot at 0x3004
    do_reset();
    lat = 0;
    push(32'h3000, 1);
    reset = 1'b0;
    wait_empty();
    STALL_D = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_req", {31'b0, im_req}, 32'd0);
      chk("stall_pc", PC, 32'h3004);
      chk("stall_valid", {31'b0, VALID_F}, 32'd1);
      chk("stall_instr", INSTR_F, memfn(32'h3004));
      tick();
    end
    push(32'h3004, 0); push(32'h3008, 0);
    STALL_D = 1'b0;
    #1;
    chk("unstall_req", {31'b0, im_req}, 32'd1);
    chk("unstall_addr", im_addr, 32'h3008);
    wait_empty();
    STALL_D = 1'b1; lat = 1000;

    // Redirect while 0x300C is outstanding: drain and drop it
    do_reset();
    lat = 0;
    push(32'h3000, 1); push(32'h3004, 0);
    reset = 1'b0;
    wait_empty();
    push(32'h3008, 0);
    lat = 1000;
    tick();
    chk("pend_req", {31'b0, im_req}, 32'd1);
    chk("pend_addr", im_addr, 32'h300C);
    chk("pend_ack", {31'b0, im_ack}, 32'd0);
    NPC_SEL = 1'b1; NPC_D = 32'h3100;
    tick();
    NPC_SEL = 1'b0;
    chk("drain_req", {31'b0, im_req}, 32'd1);
    chk("drain_addr", im_addr, 32'h300C);
    tick();
    lat = 0;
    push(32'h3100, -1);
    tick();
    chk("redir_addr", im_addr, 32'h3100);
    wait_empty();
    STALL_D = 1'b1; lat = 1000;

    // Two redirects during drain: newest wins; unaligned target
    do_reset();
    lat = 1000;
    reset = 1'b0;
    tick();
    NPC_SEL = 1'b1; NPC_D = 32'h3200;
    tick();
    NPC_D = 32'h3300;
    tick();
    NPC_SEL = 1'b0; lat = 0;
    push(32'h3300, -1);
    tick();
    chk("newest_addr", im_addr, 32'h3300);
    wait_empty();
    STALL_D = 1'b1;
    NPC_SEL = 1'b1; NPC_D = 32'h3203;
    push(32'h3200, -1);
    tick();
    NPC_SEL = 1'b0; STALL_D = 1'b0;
    #1;
    chk("align_req", {31'b0, im_req}, 32'd1);
    chk("align_addr", im_addr, 32'h3200);
    wait_empty();
    STALL_D = 1'b1; lat = 1000;

    // Counters (3 instructions, 2 bubbles), then reset mid-request
    do_reset();
    STALL_D = 1'b1; lat = 0;
    reset = 1'b0;
    tick();
    STALL_D = 1'b0; lat = 1;
    push(32'h3000, -1); push(32'h3004, 1); push(32'h3008, 1);
    wait_empty();
    STALL_D = 1'b1; lat = 1000;
    chk("fcnt", FETCH_CNT, CNT_EN ? 32'd3 : 32'd0);
    chk("bcnt", BUBBLE_CNT, CNT_EN ? 32'd2 : 32'd0);
    #1;
    chk("mid_req", {31'b0, im_req}, 32'd1);
    chk("mid_addr", im_addr, 32'h300C);
    reset = 1'b1;
    #1;
    chk("arst_req", {31'b0, im_req}, 32'd0);
    chk("arst_pc", PC, 32'h3000);
    chk("arst_valid", {31'b0, VALID_F}, 32'd0);
    chk("arst_fcnt", FETCH_CNT, 32'h0);
    chk("arst_bcnt", BUBBLE_CNT, 32'h0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("post_req", {31'b0, im_req}, 32'd1);
    chk("post_addr", im_addr, 32'h3000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. It is the producer side of the F/D pipeline register.
- Keeps the fetch PC and issues requests to instruction memory over a req/ack handshake.
- Holds each returned word in a one-entry output slot and presents PCadd4F / INSTR_F / PC to the F/D register, honouring STALL_D.
- Takes redirects (branch/jump targets) from D and inserts bubbles (nop, 32'h0) when no instruction is ready.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- NOP_WORD, 32'h0000_0000, word driven on INSTR_F when the slot is empty.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- STALL_D  in  1  F/D hold; 0 means F/D captures the outputs at this edge.
- NPC_SEL  in  1  redirect request from D, single-cycle pulse.
- NPC_D  in  32  redirect target; bits [1:0] ignored (forced 00).
- im_req  out  1  memory request valid.
- im_addr  out  32  memory word address (byte address, [1:0]=00).
- im_ack  in  1  memory response; im_rdata valid in the same cycle.
- im_rdata  in  32  instruction word.
- PCadd4F  out  32  PC + 4 of the slot instruction.
- INSTR_F  out  32  slot instruction, or NOP_WORD when the slot is empty.
- PC  out  32  address of the slot instruction.
- VALID_F  out  1  slot holds a real instruction.
- FETCH_CNT  out  32  instructions delivered to F/D (optional feature).
- BUBBLE_CNT  out  32  bubbles delivered to F/D (optional feature).

Behaviour:
- Registers:
  - pc_q: next address to fetch.
  - Slot: inst_q, pcs_q, valid_q.
  - redir_q: pending target.
  - FSM: FETCH, DRAIN.
- Reset (async): pc_q=RESET_PC, valid_q=0, inst_q=NOP_WORD, pcs_q=RESET_PC, redir_q=0, state=FETCH.
  - Outputs during reset: im_req=0, INSTR_F=NOP_WORD, PC=RESET_PC, PCadd4F=RESET_PC+4, VALID_F=0.
- Slot consumption: the slot is consumed at an edge where STALL_D=0.
  - Define free = !valid_q || !STALL_D.
- FETCH:
  - im_req = free, im_addr = pc_q.
  - Once im_req rises, im_addr stays stable until im_ack.
  - In FETCH, im_req deasserts only via redirect or reset.
- FETCH, im_ack=1, no redirect: inst_q<=im_rdata, pcs_q<=pc_q, valid_q<=1, pc_q<=pc_q+4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
  - Best case is one instruction per cycle (ack in the same cycle as req).
- FETCH, consumed with no ack: valid_q<=0, so F/D receives a bubble on the next consume.
- NPC_SEL=1 in FETCH (STALL_D is a don't-care):
  - Slot is flushed: valid_q<=0, inst_q<=NOP_WORD.
  - If im_req=1 and im_ack=0: redir_q<=NPC_D, state<=DRAIN.
  - Otherwise: pc_q<=NPC_D, stay in FETCH. An ack in the same cycle is discarded.
- DRAIN:
  - im_req=1, im_addr unchanged (protocol commitment).
  - On im_ack: data discarded, pc_q<=redir_q, state<=FETCH.
  - NPC_SEL in DRAIN overwrites redir_q (newest wins), including in the ack cycle.
  - valid_q stays 0.
- Delay slot: D raises NPC_SEL only after the delay-slot instruction has entered F/D. The redirect flushes everything younger.
- Output timing:
  - INSTR_F = valid_q ? inst_q : NOP_WORD.
  - PC = pcs_q; PCadd4F = pcs_q+4.
  - All outputs come from registers, plus one adder.
- Reset mid-transaction: the outstanding request is abandoned. The memory shares reset and drops its pending ack.

Optional Feature:
- Macro FETCH_CNT_EN.
- Defined:
  - FETCH_CNT increments on each edge with STALL_D=0 and VALID_F=1.
  - BUBBLE_CNT increments on each edge with STALL_D=0 and VALID_F=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Reset, then memory acks in the same cycle, STALL_D=0 -> F/D sees PC 0x3000, 0x3004, 0x3008 on consecutive edges with VALID_F=1; PCadd4F = PC+4.
- Memory acks 2 cycles after req -> each instruction preceded by 2 bubbles (INSTR_F=0, VALID_F=0); im_addr stable while req pending.
- Slot full at 0x3004, STALL_D=1 for 3 cycles -> im_req=0, outputs held at 0x3004; STALL_D=0 -> im_req=1 same cycle, 0x3008 follows.
- NPC_SEL with NPC_D=0x3100 while im_req=1, im_ack=0 for 0x300C -> DRAIN. The 0x300C data is dropped on ack. Next im_addr=0x3100; no 0x300C instruction ever reaches VALID_F.
- Two NPC_SEL pulses in DRAIN (0x3200, then 0x3300) -> fetch resumes at 0x3300. Also: NPC_D=0x3203 -> fetch at 0x3200.
- Assert reset during a pending request -> im_req=0 immediately, PC=0x3000; after release, first im_addr=0x3000. With FETCH_CNT_EN: 3 instructions + 2 bubbles give FETCH_CNT=3, BUBBLE_CNT=2.
